// File: rtl/vec_regfile_grouped_pkg.sv
// Shared vtype encodings, decode helpers and FSM state values for vec_regfile_grouped.
// Decoders return 0 for illegal encodings so callers can detect vill.
package vec_regfile_grouped_pkg;

    localparam logic [2:0] Sew8  = 3'b000;
    localparam logic [2:0] Sew16 = 3'b001;
    localparam logic [2:0] Sew32 = 3'b010;
    localparam logic [2:0] Sew64 = 3'b011;

    localparam logic [2:0] Lmul1 = 3'b000;
    localparam logic [2:0] Lmul2 = 3'b001;
    localparam logic [2:0] Lmul4 = 3'b010;
    localparam logic [2:0] Lmul8 = 3'b011;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StGroup = 1'b1;

    function automatic int unsigned sew_bits(input logic [2:0] vsew, input int unsigned elen);
        case (vsew)
            Sew8:    sew_bits = 32'd8;
            Sew16:   sew_bits = 32'd16;
            Sew32:   sew_bits = 32'd32;
            Sew64:   sew_bits = (elen >= 32'd64) ? 32'd64 : 32'd0;
            default: sew_bits = 32'd0;
        endcase
    endfunction

    function automatic int unsigned lmul_regs(input logic [2:0] vlmul);
        case (vlmul)
            Lmul1:   lmul_regs = 32'd1;
            Lmul2:   lmul_regs = 32'd2;
            Lmul4:   lmul_regs = 32'd4;
            Lmul8:   lmul_regs = 32'd8;
            default: lmul_regs = 32'd0;
        endcase
    endfunction

    function automatic int unsigned vlmax(input int unsigned vlen, input int unsigned sew,
                                          input int unsigned lmul);
        if (sew == 32'd0 || lmul == 32'd0) begin
            vlmax = 32'd0;
        end else begin
            vlmax = (vlen / sew) * lmul;
        end
    endfunction

endpackage

// File: rtl/vec_regfile_grouped_if.sv
// Config, write-beat, read-port and CSR status bundle for vec_regfile_grouped.
interface vec_regfile_grouped_if #(
    parameter int unsigned VLEN      = 128,
    parameter int unsigned NUM_VREGS = 32
);
    localparam int unsigned AW = $clog2(NUM_VREGS);

    logic            cfg_valid;
    logic            cfg_ready;
    logic [31:0]     cfg_avl;
    logic [2:0]      cfg_vsew;
    logic [2:0]      cfg_vlmul;
    logic            wr_valid;
    logic            wr_ready;
    logic [AW-1:0]   wr_base;
    logic            wr_vm;
    logic [VLEN-1:0] wr_data;
    logic [AW-1:0]   rd_addr_a;
    logic [AW-1:0]   rd_addr_b;
    logic [VLEN-1:0] rd_data_a;
    logic [VLEN-1:0] rd_data_b;
    logic [31:0]     vl;
    logic [31:0]     vstart;
    logic            vill;
    logic [2:0]      vsew;
    logic [2:0]      vlmul;
    logic            wr_drop;

    modport master (
        output cfg_valid, cfg_avl, cfg_vsew, cfg_vlmul,
        output wr_valid, wr_base, wr_vm, wr_data, rd_addr_a, rd_addr_b,
        input  cfg_ready, wr_ready, rd_data_a, rd_data_b,
        input  vl, vstart, vill, vsew, vlmul, wr_drop
    );

    modport slave (
        input  cfg_valid, cfg_avl, cfg_vsew, cfg_vlmul,
        input  wr_valid, wr_base, wr_vm, wr_data, rd_addr_a, rd_addr_b,
        output cfg_ready, wr_ready, rd_data_a, rd_data_b,
        output vl, vstart, vill, vsew, vlmul, wr_drop
    );

endinterface

// File: rtl/vrf_elem_enable.sv
// Per-bit write enable for one beat of a register-group write, derived from
// SEW, beat index, vl, vstart and the v0 mask.
module vrf_elem_enable
    import vec_regfile_grouped_pkg::*;
#(
    parameter int unsigned VLEN = 128
) (
    input  logic [2:0]      sew_log2_i,
    input  logic [2:0]      beat_i,
    input  logic [31:0]     vl_i,
    input  logic [31:0]     vstart_i,
    input  logic [VLEN-1:0] v0_i,
    input  logic            vm_i,
    output logic [VLEN-1:0] bit_en_o
);
    localparam int unsigned IW = $clog2(VLEN);

    logic [31:0] elems;
    logic [31:0] g;

    // g < vl <= VLEN bounds the v0 index, so truncating g is safe.
    always_comb begin
        bit_en_o = '0;
        g        = '0;
        elems    = 32'(VLEN) >> sew_log2_i;
        for (int i = 0; i < VLEN; i++) begin
            g = 32'(beat_i) * elems + (32'(i) >> sew_log2_i);
            bit_en_o[i] = (g >= vstart_i) && (g < vl_i) && (vm_i || v0_i[g[IW-1:0]]);
        end
    end

endmodule

// File: rtl/vec_regfile_grouped.sv
// Vector register file with vsetvl CSR state and multi-beat LMUL group writes.
// Define VRF_READ_BYPASS_EN for write-first reads; default is read-first.
module vec_regfile_grouped
    import vec_regfile_grouped_pkg::*;
#(
    parameter int unsigned VLEN      = 128,
    parameter int unsigned NUM_VREGS = 32,
    parameter int unsigned ELEN      = 32
) (
    input logic                  SYS_clk,
    input logic                  SYS_reset,
    vec_regfile_grouped_if.slave bus
);
    localparam int unsigned AW = $clog2(NUM_VREGS);

    logic [VLEN-1:0] vregs_q [NUM_VREGS];
    logic [0:0]      state_q;
    logic [2:0]      beat_q;
    logic [AW-1:0]   base_q;
    logic            vill_q;
    logic [2:0]      vsew_q;
    logic [2:0]      vlmul_q;
    logic [31:0]     vl_q;
    logic [31:0]     vstart_q;
    logic [VLEN-1:0] rd_a_q, rd_b_q;
    logic            wr_drop_q;

    logic            in_group, wr_apply, last_beat, cfg_fire;
    logic [2:0]      cur_beat;
    logic [AW-1:0]   cur_base, dest;
    logic [AW:0]     dest_sum;
    logic [VLEN-1:0] bit_en, merged, rd_a_d, rd_b_d;
    int unsigned     cur_lmul, new_sew, new_lmul, new_vlmax;

    vrf_elem_enable #(
        .VLEN(VLEN)
    ) u_elem_enable (
        .sew_log2_i(vsew_q + 3'd3),
        .beat_i    (cur_beat),
        .vl_i      (vl_q),
        .vstart_i  (vstart_q),
        .v0_i      (vregs_q[0]),
        .vm_i      (bus.wr_vm),
        .bit_en_o  (bit_en)
    );

    always_comb begin
        in_group  = (state_q == StGroup);
        cur_beat  = in_group ? beat_q : 3'd0;
        cur_base  = in_group ? base_q : bus.wr_base;
        dest_sum  = {1'b0, cur_base} + (AW+1)'(cur_beat);
        // Base plus beat stays below 2*NUM_VREGS, so one subtract wraps it.
        if (dest_sum >= (AW+1)'(NUM_VREGS)) begin
            dest_sum = dest_sum - (AW+1)'(NUM_VREGS);
        end
        dest      = dest_sum[AW-1:0];
        cur_lmul  = lmul_regs(vlmul_q);
        wr_apply  = bus.wr_valid && !vill_q;
        last_beat = (32'(cur_beat) == cur_lmul - 32'd1);
        merged    = (vregs_q[dest] & ~bit_en) | (bus.wr_data & bit_en);
        cfg_fire  = bus.cfg_valid && !in_group;
        new_sew   = sew_bits(bus.cfg_vsew, ELEN);
        new_lmul  = lmul_regs(bus.cfg_vlmul);
        new_vlmax = vlmax(VLEN, new_sew, new_lmul);
`ifdef VRF_READ_BYPASS_EN
        rd_a_d = (wr_apply && bus.rd_addr_a == dest) ? merged : vregs_q[bus.rd_addr_a];
        rd_b_d = (wr_apply && bus.rd_addr_b == dest) ? merged : vregs_q[bus.rd_addr_b];
`else
        rd_a_d = vregs_q[bus.rd_addr_a];
        rd_b_d = vregs_q[bus.rd_addr_b];
`endif
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            for (int i = 0; i < NUM_VREGS; i++) begin
                if (i == 0) vregs_q[i] <= '1;
                else        vregs_q[i] <= '0;
            end
            state_q   <= StIdle;
            beat_q    <= '0;
            base_q    <= '0;
            vill_q    <= 1'b1;
            vsew_q    <= '0;
            vlmul_q   <= '0;
            vl_q      <= '0;
            vstart_q  <= '0;
            rd_a_q    <= '0;
            rd_b_q    <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= bus.wr_valid && vill_q;
            rd_a_q    <= rd_a_d;
            rd_b_q    <= rd_b_d;
            if (wr_apply) begin
                vregs_q[dest] <= merged;
                if (!in_group) base_q <= bus.wr_base;
                if (last_beat) begin
                    state_q  <= StIdle;
                    beat_q   <= '0;
                    vstart_q <= '0;
                end else begin
                    state_q <= StGroup;
                    beat_q  <= cur_beat + 3'd1;
                end
            end
            if (cfg_fire) begin
                vstart_q <= '0;
                if (new_vlmax == 32'd0) begin
                    vill_q  <= 1'b1;
                    vsew_q  <= '0;
                    vlmul_q <= '0;
                    vl_q    <= '0;
                end else begin
                    vill_q  <= 1'b0;
                    vsew_q  <= bus.cfg_vsew;
                    vlmul_q <= bus.cfg_vlmul;
                    vl_q    <= (bus.cfg_avl < new_vlmax) ? bus.cfg_avl : new_vlmax;
                end
            end
        end
    end

    assign bus.cfg_ready = !in_group;
    assign bus.wr_ready  = 1'b1;
    assign bus.rd_data_a = rd_a_q;
    assign bus.rd_data_b = rd_b_q;
    assign bus.vl        = vl_q;
    assign bus.vstart    = vstart_q;
    assign bus.vill      = vill_q;
    assign bus.vsew      = vsew_q;
    assign bus.vlmul     = vlmul_q;
    assign bus.wr_drop   = wr_drop_q;

endmodule

// File: doc/vec_regfile_grouped.md
Name: vec_regfile_grouped

Overview:
- Parametrised next-generation vector register file for the RISC-V vector unit.
- Holds NUM_VREGS registers of VLEN bits and the vtype/vl/vstart CSR state; executes vsetvl configuration requests.
- Performs LMUL register-group writes as a multi-beat sequence: one register per beat, element-granular write enables from SEW, vl, vstart and the v0 mask.
- Serves two registered read ports to the vector execute stage.

Parameters:
- VLEN, 128, bits per vector register (power of two, at least 32).
- NUM_VREGS, 32, number of architectural vector registers.
- ELEN, 32, maximum element width in bits; SEW above ELEN is illegal.

Ports:
- SYS_clk  in  1  clock.
- SYS_reset  in  1  synchronous active-high reset.
- cfg_valid  in  1  vsetvl request.
- cfg_ready  out  1  config accepted (low while a group write is in progress).
- cfg_avl  in  32  application vector length.
- cfg_vsew  in  3  requested SEW encoding.
- cfg_vlmul  in  3  requested LMUL encoding.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  write beat accepted.
- wr_base  in  log2(NUM_VREGS)  group base register; sampled on the first beat only.
- wr_vm  in  1  1 = unmasked; 0 = use v0 as the mask.
- wr_data  in  VLEN  beat data.
- rd_addr_a, rd_addr_b  in  log2(NUM_VREGS)  read addresses.
- rd_data_a, rd_data_b  out  VLEN  read data.
- vl  out  32  current vl.
- vstart  out  32  current vstart.
- vill  out  1  illegal vtype.
- vsew  out  3  current SEW encoding.
- vlmul  out  3  current LMUL encoding.
- wr_drop  out  1  one-cycle pulse when a beat is discarded because vill=1.

Behaviour:
- Reset values:
  - All registers 0, except v0 = all ones.
  - vill=1, vsew=0, vlmul=0, vl=0, vstart=0.
  - FSM IDLE, beat counter 0.
  - rd_data_a/b = 0, wr_drop = 0.
  - cfg_ready=1, wr_ready=1.
- SEW decoding: 000=8, 001=16, 010=32. 011 is legal only if ELEN≥64; otherwise illegal, as are all other codes.
- LMUL decoding: 000=1, 001=2, 010=4, 011=8. Encodings 1xx are illegal in this generation.
- vsetvl: on cfg_valid and cfg_ready, at the next edge:
  - VLMAX = (VLEN/SEW)*LMUL.
  - vl = min(cfg_avl, VLMAX), vstart = 0.
  - If illegal: vill=1, vsew=0, vlmul=0, vl=0. Otherwise vill=0 and vsew/vlmul are written.
- FSM states:
  - IDLE to GROUP: on an accepted write beat when LMUL>1 and vill=0.
  - GROUP to IDLE: after beat LMUL-1 is accepted.
  - An LMUL=1 write completes entirely in IDLE.
- Beat b writes register (wr_base+b) mod NUM_VREGS. Register-number wrap-around is legal.
- Element write enable, per element j of beat b:
  - Global index g = b*(VLEN/SEW)+j.
  - Element is written iff g ≥ vstart, g < vl, and (wr_vm or v0[g]).
  - All other elements stay undisturbed (tail- and mask-undisturbed).
- g uses the v0 bit at position g. A group with VLMAX > VLEN is impossible when SEW ≥ 8, so v0 indexing never overflows.
- vstart is cleared on the last beat of a group. Writes take effect one cycle after acceptance.
- cfg_ready=0 in GROUP. wr_ready=1 always; back-pressure is reserved for future use.
- vill=1: each beat is accepted and discarded, wr_drop pulses, and the FSM stays in IDLE.
- Simultaneous cfg and first write beat in IDLE: the write uses the old vtype/vl, and the new config applies from the next cycle.
- Reset during GROUP: the group is aborted, FSM goes to IDLE, and all state takes reset values.
- Reads: 1-cycle registered latency. rd_data reflects the array contents at the sampling edge.

Optional Feature:
- Macro: VRF_READ_BYPASS_EN.
- Defined: if a read address equals the register being written in the same cycle, rd_data returns the merged post-write value (write-first).
- Undefined: rd_data returns the pre-write value (read-first); the new value is visible one cycle later.

Decomposition:
- Shared package/header:
  - SEW and LMUL encoding constants.
  - sew_bits and lmul_regs decode functions.
  - VLMAX computation.
  - FSM state encoding.
- Natural sub-module: vrf_elem_enable. Combinational; from SEW, beat index, vl, vstart, v0 and wr_vm it produces a VLEN-bit bit-enable vector.

Test Plan:
- Reset, then read v0 and v5 → v0 = all ones, v5 = 0, vill=1, vl=0; a write while vill=1 → wr_drop pulses and v5 stays 0.
- Config avl=100, vsew=010, vlmul=001 (VLEN=128) → vl=8, vill=0. Then a group write at wr_base=4, wr_vm=1, with 2 beats of all-F data → v4 and v5 become all ones; cfg_ready is low for the 1 GROUP cycle.
- Config avl=3, vsew=000, vlmul=000 → vl=3. Write a beat of all-F to v7, pre-cleared → only bytes 0–2 are set; the tail stays 0.
- v0 = 0x...0005, wr_vm=0, SEW=32, vl=4, write all-F to v2 → only elements 0 and 2 are written.
- Config vsew=011 (ELEN=32) or vlmul=100 → vill=1, vl=0, vsew=0. Assert reset mid-group (after beat 1 of LMUL=4) → FSM IDLE, registers reset, and no further beats are applied.
- Write v3 and read v3 in the same cycle → with VRF_READ_BYPASS_EN the read returns new data next cycle; without it, the read returns old data and new data one cycle later.
